// File: rtl/team_12_wb_pkg.sv
// Shared types and bus-width constants for the team_12 Wishbone master arbiter.
package team_12_wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } wbm_state_t;

endpackage

// File: rtl/team_12_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module team_12_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_req
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/team_12_wb_master_arb.sv
// Shares one classic Wishbone master port among NREQ requesters, one single-beat
// transfer per grant, with round-robin fairness and an optional ACK timeout.
module team_12_wb_master_arb
  import team_12_wb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       req_we_i,
  input  logic [NREQ*WB_AW-1:0] req_adr_i,
  input  logic [NREQ*WB_DW-1:0] req_dat_i,
  input  logic [NREQ*WB_SW-1:0] req_sel_i,
  output logic [NREQ-1:0]       req_done_o,
  output logic [NREQ-1:0]       req_err_o,
  output logic [WB_DW-1:0]      rdat_o,
  output logic [WB_AW-1:0]      ADR_O,
  output logic [WB_DW-1:0]      DAT_O,
  output logic [WB_SW-1:0]      SEL_O,
  output logic                  WE_O,
  output logic                  STB_O,
  output logic                  CYC_O,
  input  logic [WB_DW-1:0]      DAT_I,
  input  logic                  ACK_I
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  wbm_state_t      state_q, state_d;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx_q;
  logic [NREQ-1:0] gnt_oh_q;
  logic [CW-1:0]   cnt_q;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            any_req;
  logic            timeout_hit;

  team_12_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req       (req_i),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  // Fires on the BUS cycle whose increment brings the count up to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUS;
      BUS:     if (ACK_I || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rr_ptr     <= '0;
      gnt_idx_q  <= '0;
      gnt_oh_q   <= '0;
      cnt_q      <= '0;
      req_done_o <= '0;
      req_err_o  <= '0;
      rdat_o     <= '0;
      ADR_O      <= '0;
      DAT_O      <= '0;
      SEL_O      <= '0;
      WE_O       <= 1'b0;
      STB_O      <= 1'b0;
      CYC_O      <= 1'b0;
    end else begin
      req_done_o <= '0;
      req_err_o  <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            ADR_O     <= req_adr_i[int'(arb_idx)*WB_AW +: WB_AW];
            DAT_O     <= req_dat_i[int'(arb_idx)*WB_DW +: WB_DW];
            SEL_O     <= req_sel_i[int'(arb_idx)*WB_SW +: WB_SW];
            WE_O      <= req_we_i[arb_idx];
            CYC_O     <= 1'b1;
            STB_O     <= 1'b1;
            gnt_idx_q <= arb_idx;
            gnt_oh_q  <= arb_grant;
            cnt_q     <= '0;
          end
        end
        BUS: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          // ACK is checked first so a late ACK on the timeout cycle still counts as success.
          if (ACK_I) begin
            if (!WE_O) rdat_o <= DAT_I;
            CYC_O      <= 1'b0;
            STB_O      <= 1'b0;
            req_done_o <= gnt_oh_q;
          end else if (timeout_hit) begin
            CYC_O      <= 1'b0;
            STB_O      <= 1'b0;
            req_done_o <= gnt_oh_q;
            req_err_o  <= gnt_oh_q;
          end
        end
        DONE: begin
          rr_ptr <= (int'(gnt_idx_q) == NREQ - 1) ? '0 : gnt_idx_q + 1'b1;
          cnt_q  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_team_12_wb_master_arb.sv
// Scoreboard bench: each request pushes its expected bus view and completion; a
// slave/monitor process answers the bus and pops entries as done pulses appear.
module tb_team_12_wb_master_arb;

  localparam int NREQ = 2;
  localparam int TO   = 8;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic [NREQ-1:0]   req_i;
  logic [NREQ-1:0]   req_we_i;
  logic [NREQ*32-1:0] req_adr_i;
  logic [NREQ*32-1:0] req_dat_i;
  logic [NREQ*4-1:0]  req_sel_i;
  logic [NREQ-1:0]   req_done_o;
  logic [NREQ-1:0]   req_err_o;
  logic [31:0]       rdat_o;
  logic [31:0]       ADR_O;
  logic [31:0]       DAT_O;
  logic [3:0]        SEL_O;
  logic              WE_O;
  logic              STB_O;
  logic              CYC_O;
  logic [31:0]       DAT_I;
  logic              ACK_I;
  logic              slave_ack;
  logic              stray_ack;

  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          delay;
    logic        err;
    int          cycles;
    logic [31:0] rdat;
  } exp_t;

  exp_t        exp_q[$];
  int          pend[NREQ];
  int          stb_cnt;
  logic [31:0] model_rdat;
  int          total;
  int          bad;

  assign ACK_I = slave_ack | stray_ack;

  always #5 wb_clk_i = ~wb_clk_i;

  team_12_wb_master_arb #(
    .NREQ    (NREQ),
    .TIMEOUT (TO)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .req_i      (req_i),
    .req_we_i   (req_we_i),
    .req_adr_i  (req_adr_i),
    .req_dat_i  (req_dat_i),
    .req_sel_i  (req_sel_i),
    .req_done_o (req_done_o),
    .req_err_o  (req_err_o),
    .rdat_o     (rdat_o),
    .ADR_O      (ADR_O),
    .DAT_O      (DAT_O),
    .SEL_O      (SEL_O),
    .WE_O       (WE_O),
    .STB_O      (STB_O),
    .CYC_O      (CYC_O),
    .DAT_I      (DAT_I),
    .ACK_I      (ACK_I)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // delay = STB cycles until the slave ACKs; 0 means the slave never answers.
  task automatic applyStimulus(input int k, input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel,
                               input logic [31:0] rdata, input int delay);
    exp_t e;
    e.idx    = k;
    e.we     = we;
    e.adr    = adr;
    e.dat    = dat;
    e.sel    = sel;
    e.rdata  = rdata;
    e.delay  = delay;
    e.err    = (delay == 0) || (delay > TO);
    e.cycles = e.err ? TO : delay;
    if (!e.err && !we) model_rdat = rdata;
    e.rdat   = model_rdat;
    exp_q.push_back(e);
    req_we_i[k]           = we;
    req_adr_i[k*32 +: 32] = adr;
    req_dat_i[k*32 +: 32] = dat;
    req_sel_i[k*4 +: 4]   = sel;
    pend[k]++;
    req_i[k] = 1'b1;
  endtask

  task automatic waitDrain(input int max_cycles);
    int c = 0;
    while (exp_q.size() > 0 && c < max_cycles) begin
      @(negedge wb_clk_i);
      #1;
      c++;
    end
    checkOutput("drain", exp_q.size(), 0);
    if (exp_q.size() > 0) begin
      exp_q.delete();
      for (int k = 0; k < NREQ; k++) pend[k] = 0;
      req_i = '0;
    end
  endtask

  // Slave responder and completion checker.
  always @(negedge wb_clk_i) begin
    exp_t e;
    if (wb_rst_i) begin
      stb_cnt   = 0;
      slave_ack = 1'b0;
    end else begin
      if (STB_O && exp_q.size() > 0) begin
        stb_cnt++;
        checkOutput("bus_adr", ADR_O, exp_q[0].adr);
        checkOutput("bus_we", WE_O, exp_q[0].we);
        checkOutput("bus_sel", SEL_O, exp_q[0].sel);
        checkOutput("bus_cyc", CYC_O, 1);
        if (exp_q[0].we) checkOutput("bus_dat", DAT_O, exp_q[0].dat);
        slave_ack = (exp_q[0].delay != 0) && (stb_cnt == exp_q[0].delay);
        DAT_I     = exp_q[0].rdata;
      end else begin
        slave_ack = 1'b0;
      end
      if (req_done_o != '0) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_done", req_done_o, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("done_vec", req_done_o, 32'(1) << e.idx);
          checkOutput("err_vec", req_err_o, e.err ? (32'(1) << e.idx) : 32'(0));
          checkOutput("stb_cycles", stb_cnt, e.cycles);
          checkOutput("rdat", rdat_o, e.rdat);
          stb_cnt = 0;
          pend[e.idx]--;
          if (pend[e.idx] == 0) req_i[e.idx] = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total      = 0;
    bad        = 0;
    stb_cnt    = 0;
    model_rdat = 32'h0;
    for (int k = 0; k < NREQ; k++) pend[k] = 0;
    wb_rst_i   = 1'b1;
    req_i      = '0;
    req_we_i   = '0;
    req_adr_i  = '0;
    req_dat_i  = '0;
    req_sel_i  = '0;
    DAT_I      = 32'h0;
    slave_ack  = 1'b0;
    stray_ack  = 1'b0;

    repeat (3) @(negedge wb_clk_i);
    checkOutput("rst_cyc", CYC_O, 0);
    checkOutput("rst_stb", STB_O, 0);
    checkOutput("rst_done", req_done_o, 0);
    checkOutput("rst_err", req_err_o, 0);
    checkOutput("rst_rdat", rdat_o, 0);
    checkOutput("rst_adr", ADR_O, 0);
    checkOutput("rst_we", WE_O, 0);
    wb_rst_i = 1'b0;

    // Single read from requester 0, ACK on the third STB cycle.
    @(negedge wb_clk_i);
    applyStimulus(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 3);
    @(negedge wb_clk_i);
    checkOutput("t1_cyc_lat", CYC_O, 1);
    checkOutput("t1_stb_lat", STB_O, 1);
    waitDrain(50);
    checkOutput("t1_rdat", rdat_o, 32'hDEAD_BEEF);

    // Single write from requester 1; rdat must be untouched.
    @(negedge wb_clk_i);
    applyStimulus(1, 1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 32'h5555_AAAA, 2);
    waitDrain(50);
    checkOutput("t2_rdat_kept", rdat_o, 32'hDEAD_BEEF);

    // Both held with immediate ACKs: grants must alternate 0,1,0,1.
    @(negedge wb_clk_i);
    applyStimulus(0, 1'b0, 32'h0000_0100, 32'h0, 4'h3, 32'hA5A5_0001, 1);
    applyStimulus(1, 1'b1, 32'h0000_0200, 32'hCAFE_0002, 4'hC, 32'h0, 1);
    applyStimulus(0, 1'b0, 32'h0000_0100, 32'h0, 4'h3, 32'hA5A5_0003, 1);
    applyStimulus(1, 1'b1, 32'h0000_0200, 32'hCAFE_0002, 4'hC, 32'h0, 1);
    waitDrain(100);

    // Silent slave: exactly TO cycles of STB then done+err; then a normal transfer.
    @(negedge wb_clk_i);
    applyStimulus(0, 1'b0, 32'h3000_0020, 32'h0, 4'h1, 32'h7777_7777, 0);
    waitDrain(100);
    @(negedge wb_clk_i);
    applyStimulus(1, 1'b1, 32'h3000_0024, 32'h0BEE_F00D, 4'h6, 32'h0, 2);
    waitDrain(50);

    // ACK arriving on the timeout cycle must win.
    @(negedge wb_clk_i);
    applyStimulus(0, 1'b0, 32'h3000_0030, 32'h0, 4'hF, 32'h0BAD_F00D, TO);
    waitDrain(100);

    // Stray ACK while idle: nothing may happen.
    @(negedge wb_clk_i);
    stray_ack = 1'b1;
    @(negedge wb_clk_i);
    stray_ack = 1'b0;
    checkOutput("stray_cyc", CYC_O, 0);
    checkOutput("stray_done", req_done_o, 0);
    @(negedge wb_clk_i);
    checkOutput("stray_cyc2", CYC_O, 0);
    checkOutput("stray_rdat", rdat_o, 32'h0BAD_F00D);

    // Reset during BUS with the rr pointer at requester 1.
    @(negedge wb_clk_i);
    req_adr_i[32 +: 32] = 32'h3000_0040;
    req_we_i[1]         = 1'b0;
    req_i[1]            = 1'b1;
    @(negedge wb_clk_i);
    checkOutput("mid_cyc_up", CYC_O, 1);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    req_i    = '0;
    @(negedge wb_clk_i);
    checkOutput("mid_rst_cyc", CYC_O, 0);
    checkOutput("mid_rst_stb", STB_O, 0);
    checkOutput("mid_rst_done", req_done_o, 0);
    wb_rst_i   = 1'b0;
    model_rdat = 32'h0;
    @(negedge wb_clk_i);
    applyStimulus(0, 1'b0, 32'h3000_0050, 32'h0, 4'hF, 32'h1111_2222, 1);
    applyStimulus(1, 1'b1, 32'h3000_0054, 32'h3333_4444, 4'hF, 32'h0, 1);
    waitDrain(100);

    repeat (2) @(negedge wb_clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
